shift_unit_iter: RTL and testbench

- Parametrised iterative shifter for the multicycle datapath.
- Selects the shift amount from one of four sources: instruction shamt, register B, memory data, or the previous amount.
- Shifts a WIDTH-bit operand by up to STEP positions per clock.
- Reports completion through a start/busy/done handshake to the control unit.
- Replaces the combinational shift-amount selection plus single-shot shift register with one sequenced block.

---
 rtl/shift_unit_iter_if.sv | 25 ++
 rtl/shift_unit_iter.sv | 71 +++++++
 tb/tb_shift_unit_iter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shift_unit_iter_if.sv
// shift_unit_iter_if: request/result bundle between control unit and iterative shifter
interface shift_unit_iter_if #(
    parameter int WIDTH = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [2:0]         op;
    logic [1:0]         amt_sel;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   reg_b;
    logic [WIDTH-1:0]   mem_data;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   data_out;
    logic [SHAMT_W-1:0] amt_out;
    logic               busy;
    logic               done;
    modport master (
        output start, op, amt_sel, shamt, reg_b, mem_data, data_in,
        input  data_out, amt_out, busy, done
    );
    modport slave (
        input  start, op, amt_sel, shamt, reg_b, mem_data, data_in,
        output data_out, amt_out, busy, done
    );
endinterface

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multicycle shifter, up to STEP positions per clock, start/busy/done handshake
module shift_unit_iter #(
    parameter int WIDTH = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP = 4
) (
    input logic clk,
    input logic reset,
    shift_unit_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [2:0] SLL = 3'b001, SRL = 3'b010, SRA = 3'b011, ROR = 3'b100, ROL = 3'b101;
    localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_V = (SHAMT_W+1)'(WIDTH);
    state_t                    state;
    logic [WIDTH-1:0]          shreg, shifted;
    logic signed [WIDTH-1:0]   sra_v;
    logic [SHAMT_W-1:0]        cnt, amt_reg, amt_mux;
    logic [2:0]                op_reg;
    logic [SHAMT_W:0]          k, kc, rem;
    logic                      is_load;
    logic                      unused_hi;
    assign unused_hi = ^{bus.reg_b[WIDTH-1:SHAMT_W], bus.mem_data[WIDTH-1:SHAMT_W]};
    // amount source select, per-step shift distance and the shifted value for this step
    always_comb begin
        amt_mux = bus.amt_sel == 2'b00 ? bus.shamt :
                  bus.amt_sel == 2'b01 ? bus.reg_b[SHAMT_W-1:0] :
                  bus.amt_sel == 2'b10 ? bus.mem_data[SHAMT_W-1:0] : amt_reg;
        is_load = bus.op == 3'b000 || bus.op[2:1] == 2'b11;
        k = ({1'b0, cnt} < STEP_V) ? {1'b0, cnt} : STEP_V;
        kc = WIDTH_V - k;
        rem = {1'b0, cnt} - k;
        sra_v = $signed(shreg) >>> k;
        shifted = op_reg == SLL ? shreg << k :
                  op_reg == SRL ? shreg >> k :
                  op_reg == SRA ? sra_v :
                  op_reg == ROR ? (shreg >> k) | (shreg << kc) :
                  op_reg == ROL ? (shreg << k) | (shreg >> kc) : shreg;
    end
    // sequencer: accept in IDLE, chip away at the count in SHIFT, pulse DONE for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt <= '0;
            amt_reg <= '0;
            op_reg <= 3'b000;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    shreg <= bus.data_in;
                    amt_reg <= amt_mux;
                    cnt <= amt_mux;
                    op_reg <= bus.op;
                    state <= (amt_mux == '0 || is_load) ? DONE : SHIFT;
                end
                SHIFT: begin
                    shreg <= shifted;
                    cnt <= rem[SHAMT_W-1:0];
                    state <= rem == '0 ? DONE : SHIFT;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.data_out = shreg;
    assign bus.amt_out = amt_reg;
    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed checks of the iterative shifter with hand-computed results
module tb_shift_unit_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   busy_n;
    int   lat;
    logic seen;
    shift_unit_iter_if bus ();
    shift_unit_iter dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic run(input logic [2:0] o, input logic [1:0] s, input logic [4:0] sh,
                       input logic [31:0] rb, input logic [31:0] md, input logic [31:0] din,
                       input bit pulse);
        @(negedge clk);
        bus.op = o;
        bus.amt_sel = s;
        bus.shamt = sh;
        bus.reg_b = rb;
        bus.mem_data = md;
        bus.data_in = din;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data_in = 32'hA5A5A5A5;
        bus.shamt = 5'd7;
        lat = 1;
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_n++;
                bus.start = pulse && bus.busy && busy_n <= 3;
                @(negedge clk);
                lat++;
            end
        end
        bus.start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op = 3'b000;
        bus.amt_sel = 2'b00;
        bus.shamt = '0;
        bus.reg_b = '0;
        bus.mem_data = '0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_data", bus.data_out, 32'h0);
        check("rst_amt", {27'd0, bus.amt_out}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        run(3'b011, 2'b00, 5'd4, 32'h0, 32'h0, 32'h80000000, 1'b0);
        check("sra4_busy", busy_n, 1);
        check("sra4_lat", lat, 2);
        check("sra4_data", bus.data_out, 32'hF8000000);
        check("sra4_amt", {27'd0, bus.amt_out}, 32'd4);
        run(3'b001, 2'b00, 5'd31, 32'h0, 32'h0, 32'h00000001, 1'b1);
        check("sll31_busy", busy_n, 8);
        check("sll31_lat", lat, 9);
        check("sll31_data", bus.data_out, 32'h80000000);
        check("sll31_amt", {27'd0, bus.amt_out}, 32'd31);
        @(negedge clk);
        check("sll31_done_pulse", {31'd0, bus.done}, 32'd0);
        check("sll31_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("sll31_hold", bus.data_out, 32'h80000000);
        run(3'b100, 2'b01, 5'd3, 32'hFFFFFFE8, 32'h0, 32'h12345678, 1'b0);
        check("ror_regb_busy", busy_n, 2);
        check("ror_regb_data", bus.data_out, 32'h78123456);
        check("ror_regb_amt", {27'd0, bus.amt_out}, 32'd8);
        run(3'b100, 2'b10, 5'd3, 32'h0, 32'h00000028, 32'h12345678, 1'b0);
        check("ror_mem_data", bus.data_out, 32'h78123456);
        run(3'b001, 2'b00, 5'd0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        check("zero_busy", busy_n, 0);
        check("zero_lat", lat, 1);
        check("zero_data", bus.data_out, 32'hDEADBEEF);
        run(3'b111, 2'b00, 5'd5, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        check("load_busy", busy_n, 0);
        check("load_lat", lat, 1);
        check("load_data", bus.data_out, 32'hDEADBEEF);
        check("load_amt", {27'd0, bus.amt_out}, 32'd5);
        run(3'b010, 2'b00, 5'd5, 32'h0, 32'h0, 32'hF0000000, 1'b0);
        check("srl5_data", bus.data_out, 32'h07800000);
        run(3'b011, 2'b00, 5'd8, 32'h0, 32'h0, 32'h70000000, 1'b0);
        check("sra_pos_data", bus.data_out, 32'h00700000);
        run(3'b011, 2'b00, 5'd31, 32'h0, 32'h0, 32'h80000000, 1'b0);
        check("sra31_data", bus.data_out, 32'hFFFFFFFF);
        check("sra31_lat", lat, 9);
        run(3'b101, 2'b00, 5'd12, 32'h0, 32'h0, 32'h00000001, 1'b0);
        check("rol12_data", bus.data_out, 32'h00001000);
        run(3'b101, 2'b11, 5'd3, 32'h0, 32'h0, 32'h000000FF, 1'b0);
        check("reuse_amt", {27'd0, bus.amt_out}, 32'd12);
        check("reuse_data", bus.data_out, 32'h000FF000);
        run(3'b101, 2'b00, 5'd4, 32'h0, 32'h0, 32'h80000001, 1'b0);
        check("rol_wrap_data", bus.data_out, 32'h00000018);
        @(negedge clk);
        bus.op = 3'b001;
        bus.amt_sel = 2'b00;
        bus.shamt = 5'd31;
        bus.data_in = 32'h00000001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", {31'd0, bus.busy}, 32'd0);
        check("async_done", {31'd0, bus.done}, 32'd0);
        check("async_data", bus.data_out, 32'h0);
        check("async_amt", {27'd0, bus.amt_out}, 32'd0);
        @(negedge clk);
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        run(3'b100, 2'b00, 5'd4, 32'h0, 32'h0, 32'h12345678, 1'b0);
        check("post_rst_lat", lat, 2);
        check("post_rst_data", bus.data_out, 32'h81234567);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
